mac_lut_ctrl: RTL and testbench

//  Learning-switch MAC table controller behind eth_parser in the switch output_port_lookup.

---
 rtl/mac_lut_ctrl_if.sv | 26 ++
 rtl/mac_lut_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_mac_lut_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_lut_ctrl_if.sv
// Request/result bundle between the header parser side and the MAC table controller.
// master drives parsed packet fields and flush; slave returns the lookup result and status.
interface mac_lut_ctrl_if #(
    parameter int unsigned NUM_QUEUES = 8
);
    logic [47:0]           dst_mac;
    logic [47:0]           src_mac;
    logic [NUM_QUEUES-1:0] src_port;
    logic                  eth_done;
    logic                  flush;
    logic [NUM_QUEUES-1:0] dst_ports;
    logic                  lookup_done;
    logic                  flush_busy;
    logic [31:0]           lut_hit_count;
    logic [31:0]           lut_miss_count;

    modport master (
        output dst_mac, src_mac, src_port, eth_done, flush,
        input  dst_ports, lookup_done, flush_busy, lut_hit_count, lut_miss_count
    );

    modport slave (
        input  dst_mac, src_mac, src_port, eth_done, flush,
        output dst_ports, lookup_done, flush_busy, lut_hit_count, lut_miss_count
    );
endinterface

// File: rtl/mac_lut_ctrl.sv
// Learning-switch MAC table: 2-cycle lookup/learn pipeline, table flush walk, hit/miss counters.
// Optional entry aging is compiled in when MAC_LUT_AGING_EN is defined.
module mac_lut_ctrl #(
    parameter int unsigned NUM_QUEUES = 8,
    parameter int unsigned LUT_DEPTH  = 16,
    parameter int unsigned AGE_PERIOD = 1024
) (
    input  logic          clk,
    input  logic          reset,
    mac_lut_ctrl_if.slave bus
);
    localparam int unsigned MAC_W = 48;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam logic [NUM_QUEUES-1:0] PHYS_MASK = {(NUM_QUEUES / 2){2'b01}};

    if ((LUT_DEPTH < 2) || ((LUT_DEPTH & (LUT_DEPTH - 1)) != 0) ||
        (AGE_PERIOD < 1) || ((NUM_QUEUES % 2) != 0)) begin : g_param_check
        $error("mac_lut_ctrl: illegal parameter set");
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
    logic             flush_clr;
    logic             ptr_clr;

    logic                  s1_valid;
    logic [MAC_W-1:0]      s1_dst;
    logic [MAC_W-1:0]      s1_src;
    logic [NUM_QUEUES-1:0] s1_port;

    logic [LUT_DEPTH-1:0]  valid_q;
    logic [MAC_W-1:0]      mac_q  [LUT_DEPTH];
    logic [NUM_QUEUES-1:0] port_q [LUT_DEPTH];
    logic [IDX_W-1:0]      rep_ptr;

    logic                  dst_hit, src_hit, free_found;
    logic [IDX_W-1:0]      dst_idx, src_idx, free_idx;
    logic                  in_flush;
    logic [NUM_QUEUES-1:0] flood;
    logic [NUM_QUEUES-1:0] res_ports;
    logic                  count_hit, count_miss;
    logic                  learn;
    logic [IDX_W-1:0]      learn_idx;
    logic                  ptr_adv;

    logic [NUM_QUEUES-1:0] dst_ports_q;
    logic                  done_q;
    logic                  busy_q;
    logic [CNT_W-1:0]      hit_q;
    logic [CNT_W-1:0]      miss_q;

    assign bus.dst_ports      = dst_ports_q;
    assign bus.lookup_done    = done_q;
    assign bus.flush_busy     = busy_q;
    assign bus.lut_hit_count  = hit_q;
    assign bus.lut_miss_count = miss_q;

    // Flush walk state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    // Flush is accepted only from IDLE; the walk clears one entry per cycle.
    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        flush_clr   = 1'b0;
        ptr_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                    ptr_clr     = 1'b1;
                end
            end
            FLUSH: begin
                flush_clr   = 1'b1;
                flush_idx_d = flush_idx_q + IDX_W'(1);
                if (flush_idx_q == IDX_W'(LUT_DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Parallel compare; descending scan leaves the lowest matching index.
    always_comb begin
        dst_hit    = 1'b0;
        dst_idx    = '0;
        src_hit    = 1'b0;
        src_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (mac_q[i] == s1_dst)) begin
                dst_hit = 1'b1;
                dst_idx = IDX_W'(i);
            end
            if (valid_q[i] && (mac_q[i] == s1_src)) begin
                src_hit = 1'b1;
                src_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Destination result, statistics and learn target for the request in S1.
    always_comb begin
        in_flush   = (state_q == FLUSH);
        flood      = PHYS_MASK & ~s1_port;
        res_ports  = flood;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        learn      = 1'b0;
        learn_idx  = '0;
        ptr_adv    = 1'b0;
        if (s1_valid) begin
            if (in_flush) begin
                count_miss = 1'b1;
            end else begin
                if (!s1_dst[0]) begin
                    if (dst_hit) begin
                        res_ports = port_q[dst_idx] & ~s1_port;
                        count_hit = 1'b1;
                    end else begin
                        count_miss = 1'b1;
                    end
                end
                if (!s1_src[0]) begin
                    learn = 1'b1;
                    if (src_hit) begin
                        learn_idx = src_idx;
                    end else if (free_found) begin
                        learn_idx = free_idx;
                    end else begin
                        learn_idx = rep_ptr;
                        ptr_adv   = 1'b1;
                    end
                end
            end
        end
    end

`ifdef MAC_LUT_AGING_EN
    localparam int unsigned AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [AGE_W-1:0]     age_cnt;
    logic                 age_wrap;
    logic                 age_tick;
    logic [LUT_DEPTH-1:0] recent_q;

    assign age_wrap = (age_cnt == AGE_W'(AGE_PERIOD - 1));
    assign age_tick = age_wrap && (state_q != FLUSH);

    // Free-running aging timer and per-entry activity flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_cnt  <= '0;
            recent_q <= '0;
        end else begin
            age_cnt <= age_wrap ? '0 : age_cnt + AGE_W'(1);
            if (age_tick) begin
                recent_q <= '0;
            end
            if (learn) begin
                recent_q[learn_idx] <= 1'b1;
            end
        end
    end
`endif

    // Valid bits: flush clear and aging first, a learn write overrides both.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (flush_clr) begin
                valid_q[flush_idx_q] <= 1'b0;
            end
`ifdef MAC_LUT_AGING_EN
            if (age_tick) begin
                valid_q <= valid_q & recent_q;
            end
`endif
            if (learn) begin
                valid_q[learn_idx] <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (learn) begin
            mac_q[learn_idx]  <= s1_src;
            port_q[learn_idx] <= s1_port;
        end
    end

    // Request stage, replacement pointer, registered outputs and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_dst      <= '0;
            s1_src      <= '0;
            s1_port     <= '0;
            rep_ptr     <= '0;
            dst_ports_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            s1_valid <= bus.eth_done;
            if (bus.eth_done) begin
                s1_dst  <= bus.dst_mac;
                s1_src  <= bus.src_mac;
                s1_port <= bus.src_port;
            end
            if (ptr_clr) begin
                rep_ptr <= '0;
            end else if (ptr_adv) begin
                rep_ptr <= rep_ptr + IDX_W'(1);
            end
            dst_ports_q <= s1_valid ? res_ports : '0;
            done_q      <= s1_valid;
            busy_q      <= (state_d == FLUSH);
            if (count_hit) begin
                hit_q <= hit_q + CNT_W'(1);
            end
            if (count_miss) begin
                miss_q <= miss_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_lut_ctrl.sv
// Bench for mac_lut_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a slot-array reference model.
module tb_mac_lut_ctrl;
    localparam int unsigned NQ    = 8;
    localparam int unsigned DEPTH = 16;
`ifdef MAC_LUT_AGING_EN
    localparam int unsigned AGE = 16;
`else
    localparam int unsigned AGE = 1024;
`endif
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_lut_ctrl_if #(.NUM_QUEUES(NQ)) bus ();

    mac_lut_ctrl #(
        .NUM_QUEUES(NQ),
        .LUT_DEPTH (DEPTH),
        .AGE_PERIOD(AGE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Unicast test addresses keep bit 0 clear.
    function automatic logic [47:0] mac(input int n);
        return {8'(n), 40'h00_0000_0000};
    endfunction

    // ---------------- reference model ----------------
    logic          m_valid [DEPTH];
    logic [47:0]   m_mac   [DEPTH];
    logic [NQ-1:0] m_port  [DEPTH];
    logic          m_recent[DEPTH];
    int            m_ptr;
    bit            m_flushing;
    int            m_fidx;
`ifdef MAC_LUT_AGING_EN
    int            m_age;
`endif
    bit            p_valid;
    logic [47:0]   p_dst, p_src;
    logic [NQ-1:0] p_port;
    bit            e_done;
    logic [NQ-1:0] e_ports;
    bit            e_busy;
    logic [31:0]   e_hit, e_miss;

    function automatic logic [NQ-1:0] flood(input logic [NQ-1:0] port);
        logic [NQ-1:0] m;
        for (int i = 0; i < NQ; i++) m[i] = ((i % 2) == 0) && !port[i];
        return m;
    endfunction

    function automatic int find(input logic [47:0] a);
        for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_mac[i] == a) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 1'b0;
            m_recent[i] = 1'b0;
            m_mac[i]    = '0;
            m_port[i]   = '0;
        end
        m_ptr = 0; m_flushing = 1'b0; m_fidx = 0;
`ifdef MAC_LUT_AGING_EN
        m_age = 0;
`endif
        p_valid = 1'b0; p_dst = '0; p_src = '0; p_port = '0;
        e_done = 1'b0; e_ports = '0; e_busy = 1'b0; e_hit = '0; e_miss = '0;
    endtask

    task automatic model_step();
        bit was_flush;
        bit tick;
        int d, s, tgt;
        was_flush = m_flushing;
        tick = 1'b0;
        tgt = -1;
`ifdef MAC_LUT_AGING_EN
        tick = (m_age == AGE - 1);
        m_age = tick ? 0 : m_age + 1;
`endif
        e_done = p_valid;
        e_ports = '0;
        if (p_valid) begin
            d = find(p_dst);
            e_ports = flood(p_port);
            if (was_flush) e_miss++;
            else if (!p_dst[0]) begin
                if (d >= 0) begin
                    e_ports = m_port[d] & ~p_port;
                    e_hit++;
                end else e_miss++;
            end
            if (!was_flush && !p_src[0]) begin
                s = find(p_src);
                if (s >= 0) tgt = s;
                else begin
                    tgt = first_free();
                    if (tgt < 0) begin
                        tgt = m_ptr;
                        m_ptr = (m_ptr + 1) % DEPTH;
                    end
                end
            end
        end
        if (tick && !was_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!m_recent[i]) m_valid[i] = 1'b0;
                m_recent[i] = 1'b0;
            end
        end
        if (m_flushing) begin
            m_valid[m_fidx] = 1'b0;
            m_fidx++;
            if (m_fidx == DEPTH) m_flushing = 1'b0;
        end
        if (tgt >= 0) begin
            m_valid[tgt] = 1'b1; m_mac[tgt] = p_src; m_port[tgt] = p_port; m_recent[tgt] = 1'b1;
        end
        if (!was_flush && bus.flush) begin
            m_flushing = 1'b1; m_fidx = 0; m_ptr = 0;
        end
        e_busy  = m_flushing;
        p_valid = bus.eth_done;
        p_dst   = bus.dst_mac;
        p_src   = bus.src_mac;
        p_port  = bus.src_port;
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("lookup_done", bus.lookup_done, e_done);
            if (e_done) chk("dst_ports", bus.dst_ports, e_ports);
            chk("flush_busy", bus.flush_busy, e_busy);
            chk("hit_count", bus.lut_hit_count, e_hit);
            chk("miss_count", bus.lut_miss_count, e_miss);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit e, input logic [47:0] d, input logic [47:0] s,
                       input logic [NQ-1:0] p, input bit f);
        bus.eth_done = e; bus.dst_mac = d; bus.src_mac = s; bus.src_port = p; bus.flush = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    function automatic logic [47:0] pick();
        int n;
        n = int'($urandom_range(0, 23));
        if ($urandom_range(0, 7) == 0) return mac(n) | 48'h1;
        return mac(n);
    endfunction

    initial begin
        int busy_n;
        bit e, f;
        logic [47:0] d, s;
        logic [NQ-1:0] p;

        reset = 1'b1;
        idle(2);
        checking = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_done", bus.lookup_done, 0);
        chk("rst_ports", bus.dst_ports, 0);
        chk("rst_hit", bus.lut_hit_count, 0);
        chk("rst_miss", bus.lut_miss_count, 0);

        // Unknown destination floods to physical ports; source gets learned.
        cyc(1'b1, mac(2), mac(1), 8'h01, 1'b0);
        idle(1);
        chk("t1_done", bus.lookup_done, 1);
        chk("t1_ports", bus.dst_ports, 8'h54);
        chk("t1_miss", bus.lut_miss_count, 1);

        // Learned destination hits; back-to-back request sees the previous learn.
        cyc(1'b1, mac(1), mac(2), 8'h04, 1'b0);
        cyc(1'b1, mac(2), mac(3), 8'h10, 1'b0);
        chk("t2a_ports", bus.dst_ports, 8'h01);
        chk("t2a_hit", bus.lut_hit_count, 1);
        idle(1);
        chk("t2b_ports", bus.dst_ports, 8'h04);
        chk("t2b_hit", bus.lut_hit_count, 2);

        // Same-port destination drops; group destination floods without counting.
        cyc(1'b1, mac(1), mac(1), 8'h01, 1'b0);
        idle(1);
        chk("t3_drop", bus.dst_ports, 8'h00);
        chk("t3_hit", bus.lut_hit_count, 3);
        cyc(1'b1, BCAST, mac(3), 8'h04, 1'b0);
        idle(1);
        chk("t3_group", bus.dst_ports, 8'h51);
        chk("t3_cnt", bus.lut_miss_count, 1);

        // Reset drops the in-flight request.
        cyc(1'b1, mac(1), mac(2), 8'h01, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        chk("rst_drop", bus.lookup_done, 0);
        chk("rst_drop_hit", bus.lut_hit_count, 0);

        // Fill the table, then replacement walks from entry 0.
        for (int i = 0; i < 17; i++) cyc(1'b1, BCAST, mac(16 + i), 8'h04, 1'b0);
        idle(1);
        cyc(1'b1, mac(16), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t4_evicted", bus.dst_ports, 8'h45);
        chk("t4_miss", bus.lut_miss_count, 1);
        cyc(1'b1, mac(17), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t4_kept", bus.dst_ports, 8'h04);
        cyc(1'b1, BCAST, mac(41), 8'h04, 1'b0);
        cyc(1'b1, mac(17), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t4_ptr1", bus.dst_ports, 8'h45);

        // Flush walk: busy for DEPTH cycles, requests flood and do not learn.
        busy_n = 0;
        cyc(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            if (bus.flush_busy) busy_n++;
            cyc(i < 15, mac(18), mac(50), 8'h01, i == 3);
        end
        chk("t5_busy_len", 64'(busy_n), 16);
        cyc(1'b1, mac(18), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t5_after", bus.dst_ports, 8'h45);
        cyc(1'b1, mac(50), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t5_nolearn", bus.dst_ports, 8'h45);

`ifdef MAC_LUT_AGING_EN
        // Aging: survives one tick, gone after two; periodic source refresh keeps it.
        do_reset();
        cyc(1'b1, BCAST, mac(60), 8'h04, 1'b0);
        idle(10);
        cyc(1'b1, mac(60), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t6_alive", bus.dst_ports, 8'h04);
        idle(40);
        cyc(1'b1, mac(60), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t6_aged", bus.dst_ports, 8'h45);
        cyc(1'b1, BCAST, mac(60), 8'h04, 1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(7);
            cyc(1'b1, BCAST, mac(60), 8'h04, 1'b0);
        end
        idle(7);
        cyc(1'b1, mac(60), BCAST, 8'h10, 1'b0);
        idle(1);
        chk("t6_refresh", bus.dst_ports, 8'h04);
`endif

        // Random traffic with occasional flush and reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            e = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 149) == 0);
            d = pick();
            s = pick();
            p = '0;
            p[$urandom_range(0, NQ - 1)] = 1'b1;
            reset = ($urandom_range(0, 599) == 0);
            cyc(e, d, s, p, f);
        end
        reset = 1'b0;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
